// File: rtl/ir_queue.sv
// Instruction buffer: DEPTH-entry FIFO of {instruction, PC} pairs with valid/ready on both sides and flush.
// Define IR_QUEUE_BYPASS_EN to let an instruction pass straight to decode when the buffer is empty.
module ir_queue #(
    parameter int WIDTH    = 32,
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int unsigned DEPTH_U = DEPTH;

    logic [WIDTH-1:0]    instr_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    logic stored;
    logic bypass;
    logic push;
    logic pop;

    always_comb begin
        stored   = (count != '0);
        in_ready = (count < CW'(DEPTH));
`ifdef IR_QUEUE_BYPASS_EN
        bypass   = !stored && in_valid && !flush;
`else
        bypass   = 1'b0;
`endif
        out_valid = stored || bypass;
        out_instr = '0;
        out_pc    = '0;
        if (bypass) begin
            out_instr = in_instr;
            out_pc    = in_pc;
        end else if (stored) begin
            out_instr = instr_mem[rd_ptr];
            out_pc    = pc_mem[rd_ptr];
        end
        // A bypassed instruction that decode takes this cycle never enters storage.
        pop  = stored && out_ready && !flush;
        push = in_valid && in_ready && !flush && !(bypass && out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= in_instr;
                pc_mem[wr_ptr]    <= in_pc;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_queue.sv
// Randomized self-checking bench for ir_queue against a queue-based reference model.
// Builds with or without IR_QUEUE_BYPASS_EN; the model follows the same macro.
module tb_ir_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int vectors;
    int miscompares;

    logic [63:0] mq[$];

    ir_queue #(.WIDTH(32), .PC_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic bit bypass_on();
`ifdef IR_QUEUE_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Expected combinational outputs for the current inputs and model contents.
    function automatic void model_out(output bit ev, output logic [31:0] ei, output logic [31:0] ep);
        ev = 1'b0; ei = '0; ep = '0;
        if (mq.size() > 0) begin
            ev = 1'b1; ei = mq[0][63:32]; ep = mq[0][31:0];
        end else if (bypass_on() && in_valid && !flush) begin
            ev = 1'b1; ei = in_instr; ep = in_pc;
        end
    endfunction

    function automatic void model_edge();
        int n = mq.size();
        if (flush) begin
            mq.delete();
        end else if (bypass_on() && n == 0 && in_valid && out_ready) begin
            // consumed straight through, nothing stored
        end else begin
            if (n > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && n < DEPTH) mq.push_back({in_instr, in_pc});
        end
    endfunction

    task automatic drive(input bit v, input logic [31:0] i, input logic [31:0] p, input bit r, input bit f);
        in_valid = v; in_instr = i; in_pc = p; out_ready = r; flush = f;
        #1;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, '0, '0, 0, 0);
        vectors++;
        if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_instr !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state got cnt=%0d rdy=%b vld=%b instr=%h want 0 1 0 0", count, in_ready, out_valid, out_instr);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h1000_0000 + k, 32'(4 * k), 0, 0);
            step();
        end
        drive(0, '0, '0, 0, 0);
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL reset_precount got %0d want 3", count);
        end
        #2 rst = 1'b1;
        mq.delete();
        #1;
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== 32'd0 || out_pc !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_async got cnt=%0d vld=%b instr=%h pc=%h want 0 0 0 0", count, out_valid, out_instr, out_pc);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_fill_drain();
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h2008_0001 + k, 32'(4 * k), 0, 0);
            step();
        end
        drive(1, 32'hDEAD_BEEF, 32'h10, 0, 0);
        vectors++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full got cnt=%0d rdy=%b want 4 0", count, in_ready);
        end
        step();
        vectors++;
        if (count !== 3'd4) begin
            miscompares++;
            $display("FAIL fill_fifth_ignored got cnt=%0d want 4", count);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, '0, '0, 1, 0);
            vectors++;
            if (out_valid !== 1'b1 || out_instr !== 32'h2008_0001 + k || out_pc !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL drain_%0d got vld=%b instr=%h pc=%h want 1 %h %h", k, out_valid, out_instr, out_pc, 32'h2008_0001 + k, 32'(4 * k));
            end
            step();
        end
        drive(0, '0, '0, 1, 0);
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_instr !== 32'd0) begin
            miscompares++;
            $display("FAIL drain_empty got vld=%b cnt=%0d instr=%h want 0 0 0", out_valid, count, out_instr);
        end
    endtask

    task automatic test_wrap();
        bit ev; logic [31:0] ei, ep;
        for (int k = 0; k < 2; k++) begin
            drive(1, $urandom, $urandom, 0, 0);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1, $urandom, $urandom, 1, 0);
            model_out(ev, ei, ep);
            vectors++;
            if (count !== 3'd2 || out_valid !== ev || out_instr !== ei || out_pc !== ep) begin
                miscompares++;
                $display("FAIL wrap_%0d got cnt=%0d instr=%h pc=%h want 2 %h %h", k, count, out_instr, out_pc, ei, ep);
            end
            step();
        end
        drive(0, '0, '0, 0, 1);
        step();
    endtask

    task automatic test_full_pop();
        bit ev; logic [31:0] ei, ep;
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h4000_0000 + k, 32'h100 + 4 * k, 0, 0);
            step();
        end
        drive(1, 32'h5555_AAAA, 32'h200, 1, 0);
        vectors++;
        if (in_ready !== 1'b0 || count !== 3'd4 || out_instr !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL full_pop_pre got rdy=%b cnt=%0d instr=%h want 0 4 40000000", in_ready, count, out_instr);
        end
        step();
        drive(0, '0, '0, 1, 0);
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL full_pop_count got %0d want 3", count);
        end
        for (int k = 0; k < 4; k++) begin
            model_out(ev, ei, ep);
            vectors++;
            if (out_valid !== ev || out_instr !== ei || out_pc !== ep) begin
                miscompares++;
                $display("FAIL full_pop_drain_%0d got vld=%b instr=%h pc=%h want %b %h %h", k, out_valid, out_instr, out_pc, ev, ei, ep);
            end
            step();
            drive(0, '0, '0, 1, 0);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h0600_0000 + k, 32'(8 * k), 0, 0);
            step();
        end
        drive(1, 32'h0800_0010, 32'h40, 1, 1);
        step();
        drive(0, '0, '0, 1, 0);
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear got cnt=%0d vld=%b want 0 0", count, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || out_instr === 32'h0800_0010) begin
                miscompares++;
                $display("FAIL flush_dropped_%0d got vld=%b instr=%h want 0 00000000", k, out_valid, out_instr);
            end
        end
    endtask

    task automatic test_random();
        bit ev; logic [31:0] ei, ep;
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 19) == 0);
            model_out(ev, ei, ep);
            vectors++;
            if (out_valid !== ev || out_instr !== ei || out_pc !== ep) begin
                miscompares++;
                $display("FAIL rand_out_%0d got vld=%b instr=%h pc=%h want %b %h %h", k, out_valid, out_instr, out_pc, ev, ei, ep);
            end
            vectors++;
            if (count !== 3'(mq.size()) || in_ready !== (mq.size() < DEPTH)) begin
                miscompares++;
                $display("FAIL rand_cnt_%0d got cnt=%0d rdy=%b want %0d %b", k, count, in_ready, mq.size(), mq.size() < DEPTH);
            end
            step();
        end
        drive(0, '0, '0, 0, 1);
        step();
    endtask

`ifdef IR_QUEUE_BYPASS_EN
    task automatic test_bypass();
        drive(1, 32'h3C01_0000, 32'h80, 1, 0);
        vectors++;
        if (out_valid !== 1'b1 || out_instr !== 32'h3C01_0000 || out_pc !== 32'h80) begin
            miscompares++;
            $display("FAIL bypass_same_cycle got vld=%b instr=%h pc=%h want 1 3c010000 00000080", out_valid, out_instr, out_pc);
        end
        step();
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL bypass_consumed got cnt=%0d want 0", count);
        end
        drive(1, 32'h3C01_0000, 32'h84, 0, 0);
        step();
        drive(0, '0, '0, 0, 0);
        vectors++;
        if (count !== 3'd1 || out_instr !== 32'h3C01_0000 || out_pc !== 32'h84) begin
            miscompares++;
            $display("FAIL bypass_stored got cnt=%0d instr=%h pc=%h want 1 3c010000 00000084", count, out_instr, out_pc);
        end
        drive(0, '0, '0, 0, 1);
        step();
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_pop();
        test_flush();
`ifdef IR_QUEUE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction buffer between instruction memory and the decode stage. It replaces the single enable-controlled instruction register with a DEPTH-entry FIFO of {instruction, PC} pairs. Valid/ready handshakes sit on both sides, and a flush input discards all buffered instructions on a branch, jump or exception redirect. An optional bypass lets an instruction reach decode in the same cycle it arrives when the buffer is empty.

## Interface

Parameters:
- WIDTH, 32, instruction width in bits.
- PC_WIDTH, 32, width of the PC tag stored with each instruction.
- DEPTH, 4, number of entries; power of two, ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high. Clears all state immediately.
- flush  input  1  discard all entries and any same-cycle input.
- in_valid  input  1  fetch side presents an instruction.
- in_ready  output  1  buffer can accept; equals (count < DEPTH).
- in_instr  input  WIDTH  incoming instruction.
- in_pc  input  PC_WIDTH  PC of incoming instruction.
- out_valid  output  1  head instruction available to decode.
- out_ready  input  1  decode consumes head this cycle.
- out_instr  output  WIDTH  head instruction; 0 when out_valid=0.
- out_pc  output  PC_WIDTH  head PC; 0 when out_valid=0.
- count  output  $clog2(DEPTH+1)  number of stored entries.

## Operation

- Storage: DEPTH entries, write pointer and read pointer, each $clog2(DEPTH) bits, plus an occupancy counter.
- Pointers wrap modulo DEPTH. Natural overflow is used, since DEPTH is a power of two.
- Push: occurs when in_valid & in_ready & !flush (and the bypass has not consumed the input). Writes {in_instr, in_pc} at the write pointer, then increments it.
- Pop: occurs when out_valid & out_ready & !flush, with the head taken from storage. Increments the read pointer.
- Count update:
  - push only: +1
  - pop only: −1
  - both: unchanged
- in_ready depends only on count; there is no combinational path from out_ready. When full, a simultaneous pop does not open a slot in that cycle.
- out_valid = (count != 0) without the bypass.
- out_instr/out_pc are read combinationally from the head entry, masked to 0 when out_valid=0.
- Flush has priority over push and pop. The next state is pointers=0, count=0. Input presented in the flush cycle is dropped, even if in_ready=1.
- Stored data is not cleared by flush; it is masked by out_valid.
- Reset:
  - pointers, count and storage go to 0.
  - outputs: in_ready=1, out_valid=0, out_instr=0, out_pc=0, count=0.

## Timing

- Latency without the bypass: an instruction accepted at edge N appears on out_* with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one push and one pop per cycle. With count between 1 and DEPTH−1 under continuous traffic, count stays constant.
- Empty: out_valid=0, and out_ready is ignored.
- Full: in_ready=0, and in_valid is ignored with no state change.
- Flush: asserted in cycle N gives out_valid=0 and count=0 from edge N onward. New pushes are accepted from cycle N+1.
- rst asserted mid-operation: outputs return to reset values immediately, without waiting for a clock edge. Deassertion takes effect at the next edge.

## Configuration

- IR_QUEUE_BYPASS_EN defined:
  - Condition: count==0 & in_valid & !flush.
  - Then out_valid=1 combinationally, with out_instr=in_instr and out_pc=in_pc.
  - If out_ready=1 in that cycle, the instruction is consumed and not written (count stays 0).
  - If out_ready=0, it is pushed normally (count becomes 1).
  - Zero-cycle latency when empty.
- IR_QUEUE_BYPASS_EN undefined:
  - No in→out combinational path.
  - Minimum latency is one cycle, as described above.

## Test plan

- Reset:
  - Assert rst between edges with count=3 → count=0, out_valid=0, out_instr=0 immediately, with no clock edge needed.
  - After release → in_ready=1.
- Fill/drain:
  - Push 0x20080001..0x20080004 with PCs 0x0,0x4,0x8,0xC, out_ready=0 → count=4, in_ready=0.
  - A 5th push is ignored.
  - Then out_ready=1 for 4 cycles → outputs in order with matching PCs, then out_valid=0.
- Wrap-around: 10 cycles of continuous push+pop with DEPTH=4 and a base occupancy of 2 → count stays 2, output order matches input order across the pointer wrap.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 → in_ready=0, the pop occurs, count=3, and the input is not accepted that cycle.
- Flush: count=3, flush=1 with in_valid=1 (instr 0x08000010) → next cycle count=0, out_valid=0, 0x08000010 never appears at the output.
- Bypass:
  - Defines IR_QUEUE_BYPASS_EN.
  - With empty, in_valid=1, instr 0x3C010000, out_ready=1 → same-cycle out_valid=1, out_instr=0x3C010000, count remains 0.
  - With out_ready=0 instead → count=1 after the edge.
